// File: rtl/miso_delay_calibrator.sv
// miso_delay_calibrator: sweeps per-lane MISO sampling delays, probes each step and programs each lane with its widest-window centre.
// Define MISO_CAL_MULTI_PROBE_EN to AND three probe rounds per delay step.
module miso_delay_calibrator #(
  parameter int NUM_LANES     = 8,
  parameter int DELAY_W       = 4,
  parameter int DELAY_MAX     = 15,
  parameter int SETTLE_CYCLES = 16,
  parameter int DEFAULT_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [NUM_LANES*DELAY_W-1:0] cfg_data,
  output logic                         cfg_valid,
  input  logic                         cfg_ready,
  output logic                         probe_req,
  input  logic                         probe_ack,
  input  logic [NUM_LANES-1:0]         probe_pass,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_LANES-1:0]         lane_fail,
  output logic [NUM_LANES*DELAY_W-1:0] result_word
);
  localparam int CW = NUM_LANES * DELAY_W;
  localparam int IW = DELAY_MAX > 0 ? $clog2(DELAY_MAX + 1) : 1;
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = DELAY_W + 1;
`ifdef MISO_CAL_MULTI_PROBE_EN
  localparam int ROUNDS = 3;
`else
  localparam int ROUNDS = 1;
`endif
  localparam logic [IW-1:0] D_LAST = IW'(DELAY_MAX);
  localparam logic [LW-1:0] L_LAST = LW'(NUM_LANES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]    R_LAST = 2'(ROUNDS - 1);
  typedef enum logic [2:0] {IDLE, SET_CFG, SETTLE, PROBE, WAIT_PROBE, ANALYZE, SET_FINAL, DONE} state_t;
  state_t                            state_q;
  logic [IW-1:0]                     d_q;
  logic [LW-1:0]                     lane_q;
  logic [SW-1:0]                     settle_q;
  logic [1:0]                        rnd_q;
  logic [NUM_LANES-1:0]              acc_q;
  logic [NUM_LANES-1:0][DELAY_MAX:0] bitmap_q;
  logic [RW-1:0]                     run_len_q, best_len_q;
  logic [DELAY_W-1:0]                run_start_q, best_start_q;
  logic [CW-1:0]                     final_q, cfg_data_q, result_word_q;
  logic [NUM_LANES-1:0]              lane_fail_q;
  logic                              cfg_valid_q, probe_req_q, busy_q, done_q;
  logic                              bit_c, take;
  logic [RW-1:0]                     cur_len, prev_best, run_len_d, best_len_d, half;
  logic [DELAY_W-1:0]                run_start_d, best_start_d, lane_res_d;
  logic [CW-1:0]                     final_d;
  logic [NUM_LANES-1:0]              lane_fail_d, sample_d;
  // Run/best trackers restart at d==0 so each lane's windows never wrap or leak across lanes.
  always_comb begin
    bit_c        = bitmap_q[lane_q][d_q];
    cur_len      = d_q == '0 ? '0 : run_len_q;
    prev_best    = d_q == '0 ? '0 : best_len_q;
    run_len_d    = bit_c ? cur_len + RW'(1) : '0;
    run_start_d  = (bit_c && cur_len == '0) ? DELAY_W'(d_q) : run_start_q;
    take         = bit_c && (run_len_d > prev_best);
    best_len_d   = take ? run_len_d : prev_best;
    best_start_d = take ? run_start_d : best_start_q;
    half         = (best_len_d - RW'(1)) >> 1;
    lane_res_d   = best_len_d == '0 ? DELAY_W'(DEFAULT_DELAY) : best_start_d + DELAY_W'(half);
    final_d      = final_q;
    final_d[lane_q*DELAY_W +: DELAY_W] = lane_res_d;
    lane_fail_d  = lane_fail_q;
    lane_fail_d[lane_q] = best_len_d == '0;
    sample_d     = acc_q & probe_pass;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      d_q           <= '0;
      lane_q        <= '0;
      settle_q      <= '0;
      rnd_q         <= '0;
      acc_q         <= '1;
      bitmap_q      <= '0;
      run_len_q     <= '0;
      best_len_q    <= '0;
      run_start_q   <= '0;
      best_start_q  <= '0;
      final_q       <= '0;
      cfg_data_q    <= '0;
      result_word_q <= '0;
      lane_fail_q   <= '0;
      cfg_valid_q   <= 1'b0;
      probe_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      probe_req_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          d_q         <= '0;
          rnd_q       <= '0;
          acc_q       <= '1;
          bitmap_q    <= '0;
          final_q     <= '0;
          lane_fail_q <= '0;
          busy_q      <= 1'b1;
          cfg_data_q  <= '0;
          cfg_valid_q <= 1'b1;
          state_q     <= SET_CFG;
        end
        SET_CFG: if (cfg_ready) begin
          cfg_valid_q <= 1'b0;
          settle_q    <= '0;
          state_q     <= SETTLE;
        end
        SETTLE: if (settle_q == S_LAST) begin
          probe_req_q <= 1'b1;
          state_q     <= PROBE;
        end else settle_q <= settle_q + SW'(1);
        PROBE: state_q <= WAIT_PROBE;
        WAIT_PROBE: if (probe_ack) begin
          if (rnd_q != R_LAST) begin
            acc_q    <= sample_d;
            rnd_q    <= rnd_q + 2'd1;
            settle_q <= '0;
            state_q  <= SETTLE;
          end else begin
            for (int k = 0; k < NUM_LANES; k++) bitmap_q[k][d_q] <= sample_d[k];
            acc_q <= '1;
            rnd_q <= '0;
            if (d_q == D_LAST) begin
              d_q     <= '0;
              lane_q  <= '0;
              state_q <= ANALYZE;
            end else begin
              d_q         <= d_q + IW'(1);
              cfg_data_q  <= {NUM_LANES{DELAY_W'(d_q + IW'(1))}};
              cfg_valid_q <= 1'b1;
              state_q     <= SET_CFG;
            end
          end
        end
        ANALYZE: begin
          run_len_q    <= run_len_d;
          run_start_q  <= run_start_d;
          best_len_q   <= best_len_d;
          best_start_q <= best_start_d;
          if (d_q == D_LAST) begin
            d_q         <= '0;
            final_q     <= final_d;
            lane_fail_q <= lane_fail_d;
            if (lane_q == L_LAST) begin
              cfg_data_q  <= final_d;
              cfg_valid_q <= 1'b1;
              state_q     <= SET_FINAL;
            end else lane_q <= lane_q + LW'(1);
          end else d_q <= d_q + IW'(1);
        end
        SET_FINAL: if (cfg_ready) begin
          cfg_valid_q   <= 1'b0;
          result_word_q <= cfg_data_q;
          done_q        <= 1'b1;
          state_q       <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cfg_data    = cfg_data_q;
  assign cfg_valid   = cfg_valid_q;
  assign probe_req   = probe_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign lane_fail   = lane_fail_q;
  assign result_word = result_word_q;
endmodule

// File: tb/tb_miso_delay_calibrator.sv
// tb_miso_delay_calibrator: table vectors, stalled/reset sequences and random masks against a window-search model.
module tb_miso_delay_calibrator;
  localparam int NL = 8, DW = 4, DMAX = 15, SET = 16, DEF = 2, CW = NL * DW, NSTEP = DMAX + 1;
`ifdef MISO_CAL_MULTI_PROBE_EN
  localparam int NPROBE = 3 * NSTEP;
`else
  localparam int NPROBE = NSTEP;
`endif
  typedef logic [NL-1:0][DMAX:0] mask_t;
  typedef struct {
    mask_t         m;
    logic [CW-1:0] res;
    logic [NL-1:0] fail;
  } vec_t;
  logic          clk = 0, rst = 1, start = 0;
  logic [CW-1:0] cfg_data, result_word;
  logic          cfg_valid, probe_req, busy, done;
  logic          cfg_ready = 0, probe_ack = 0;
  logic [NL-1:0] probe_pass = '0, lane_fail;
  mask_t         masks = '0;
  int            stall = 0, pdly = 1, pend = 0, vcnt = 0, since = 0, nprobe = 0, ndone = 0;
  bit            stray = 0, prev_req = 0, prev_done = 0;
  logic [CW-1:0] held = '0, last_cfg = '0;
  logic [CW-1:0] log_q[$];
  int            errors = 0, checks = 0;
  miso_delay_calibrator #(.NUM_LANES(NL), .DELAY_W(DW), .DELAY_MAX(DMAX), .SETTLE_CYCLES(SET), .DEFAULT_DELAY(DEF)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .probe_req(probe_req), .probe_ack(probe_ack), .probe_pass(probe_pass), .busy(busy), .done(done),
    .lane_fail(lane_fail), .result_word(result_word)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [NL-1:0] pass_of(input logic [CW-1:0] w);
    logic [NL-1:0] p;
    for (int k = 0; k < NL; k++) p[k] = masks[k][w[k*DW +: DW]];
    return p;
  endfunction
  // Reference: enumerate every maximal run per lane, keep the first strictly longest.
  task automatic model(input mask_t m, output logic [CW-1:0] res, output logic [NL-1:0] fail);
    res = '0;
    fail = '0;
    for (int k = 0; k < NL; k++) begin
      int bl = 0, bs = 0;
      for (int s = 0; s <= DMAX; s++) begin
        if (m[k][s] && (s == 0 || !m[k][s-1])) begin
          int len = 0;
          while (s + len <= DMAX && m[k][s+len]) len++;
          if (len > bl) begin bl = len; bs = s; end
        end
      end
      res[k*DW +: DW] = bl == 0 ? DW'(DEF) : DW'(bs + (bl - 1) / 2);
      fail[k] = bl == 0;
    end
  endtask
  always @(negedge clk) begin
    since++;
    probe_ack = 1'b0;
    if (!rst) begin
      if (cfg_valid) begin
        if (vcnt == 0) held = cfg_data;
        else chk("cfg_stable", cfg_data, held);
        cfg_ready = vcnt >= stall;
        if (cfg_ready) begin
          log_q.push_back(cfg_data);
          last_cfg = cfg_data;
          vcnt = 0;
          since = 0;
        end else vcnt++;
      end else begin
        if (vcnt != 0) chk("cfg_valid_hold", cfg_valid, 1);
        vcnt = 0;
        cfg_ready = stall == 0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          probe_ack = 1'b1;
          probe_pass = pass_of(last_cfg);
          since = 0;
          nprobe++;
        end
      end else if (stray && cfg_valid && $urandom_range(0, 2) == 0) begin
        probe_ack = 1'b1;
        probe_pass = NL'($urandom);
      end
      if (probe_req) begin
        chk("probe_pulse", prev_req, 0);
        chk("settle_gap", since, SET + 1);
        pend = pdly;
      end
      prev_req = probe_req;
      if (done) begin
        ndone++;
        chk("done_pulse", prev_done, 0);
      end
      prev_done = done;
    end
  end
  task automatic clear_tb();
    log_q.delete();
    nprobe = 0;
    ndone = 0;
    pend = 0;
    vcnt = 0;
    prev_req = 0;
    prev_done = 0;
  endtask
  task automatic run(input vec_t v, input int stl, input int pd, input bit se, input bit ham);
    int n = 0;
    bit got = 0;
    logic [CW-1:0] exp;
    masks = v.m;
    stall = stl;
    pdly = pd;
    stray = se;
    clear_tb();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("busy_on", busy, 1);
    while (!got && n < 20000) begin
      @(negedge clk);
      start = 0;
      n++;
      if (done) got = 1;
      else if (ham && busy && $urandom_range(0, 15) == 0) start = 1;
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("busy_in_done", busy, 1);
      chk("result_word", result_word, v.res);
      chk("lane_fail", lane_fail, v.fail);
      chk("cfg_data_final", cfg_data, v.res);
      @(negedge clk);
      #1;
      chk("busy_off", busy, 0);
      chk("done_off", done, 0);
      chk("write_count", log_q.size(), NSTEP + 1);
      for (int i = 0; i < log_q.size() && i <= NSTEP; i++) begin
        exp = i < NSTEP ? {NL{DW'(i)}} : v.res;
        chk($sformatf("write_%0d", i), log_q[i], exp);
      end
      chk("probe_count", nprobe, NPROBE);
      chk("done_count", ndone, 1);
    end
  endtask
  initial begin
    vec_t tv[4];
    vec_t rv;
    int n;
    for (int k = 0; k < NL; k++) begin
      tv[0].m[k] = 16'h00F8;
      tv[1].m[k] = 16'h001F << k;
      tv[2].m[k] = k == 2 ? 16'h0000 : 16'h0070;
      tv[3].m[k] = k == 0 ? 16'h070E : 16'hF000;
    end
    tv[0].res = 32'h5555_5555; tv[0].fail = 8'h00;
    tv[1].res = 32'h9876_5432; tv[1].fail = 8'h00;
    tv[2].res = 32'h5555_5255; tv[2].fail = 8'h04;
    tv[3].res = 32'hDDDD_DDD2; tv[3].fail = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_probe_req", probe_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lane_fail", lane_fail, 0);
    chk("rst_result_word", result_word, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) run(tv[i], 0, 1, 0, 0);
    run(tv[0], 10, 50, 1, 0);
    masks = tv[0].m;
    stall = 0;
    pdly = 1;
    stray = 0;
    clear_tb();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (log_q.size() < 7 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_d6", log_q.size(), 7);
    if (log_q.size() == 7) chk("write_d6", log_q[6], 32'h6666_6666);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_cfg_data", cfg_data, 0);
    chk("arst_cfg_valid", cfg_valid, 0);
    chk("arst_probe_req", probe_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_lane_fail", lane_fail, 0);
    chk("arst_result_word", result_word, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    clear_tb();
    run(tv[2], 0, 2, 1, 1);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NL; k++) begin
        int mode = $urandom_range(0, 4);
        int s = $urandom_range(0, DMAX);
        int l = $urandom_range(1, DMAX + 1 - s);
        rv.m[k] = mode == 0 ? 16'h0000 : mode < 3 ? 16'(((1 << l) - 1) << s) : 16'($urandom);
      end
      model(rv.m, rv.res, rv.fail);
      run(rv, $urandom_range(0, 3), $urandom_range(1, 6), 1, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
